// File: rtl/ahblite_slave_master_reg.sv
// Registered AHB-Lite bridge: upstream slave port, downstream master port.
// Each accepted transfer is latched and replayed downstream as a single
// NONSEQ through a small FSM. This breaks every combinational path between
// the two buses. Downstream errors are returned upstream as a two-cycle
// ERROR response. A downstream stall that lasts too long is abandoned and
// reported upstream as ERROR.
module ahblite_slave_master_reg #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,   // 32 or 64
  parameter int TIMEOUT_CYCLES = 256   // 0 disables the stall timeout
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  // upstream slave port
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic [ADDR_WIDTH-1:0] HADDR_MASTER,
  input  logic [1:0]            HTRANS_MASTER,
  input  logic [2:0]            HSIZE_MASTER,
  input  logic [2:0]            HBURST_MASTER,
  input  logic [3:0]            HPROT_MASTER,
  input  logic                  HWRITE_MASTER,
  input  logic                  HMASTLOCK_MASTER,
  input  logic [DATA_WIDTH-1:0] HWDATA_MASTER,
  output logic [DATA_WIDTH-1:0] HRDATA_MASTER,
  output logic [1:0]            HRESP_MASTER,
  output logic                  HREADYOUT_MASTER,
  // downstream master port
  output logic [ADDR_WIDTH-1:0] HADDR_SLAVE,
  output logic [1:0]            HTRANS_SLAVE,
  output logic [2:0]            HSIZE_SLAVE,
  output logic [2:0]            HBURST_SLAVE,
  output logic [3:0]            HPROT_SLAVE,
  output logic                  HWRITE_SLAVE,
  output logic                  HMASTLOCK_SLAVE,
  output logic [DATA_WIDTH-1:0] HWDATA_SLAVE,
  input  logic [DATA_WIDTH-1:0] HRDATA_SLAVE,
  input  logic [1:0]            HRESP_SLAVE,
  input  logic                  HREADY_SLAVE,
  output logic                  TIMEOUT_PULSE
);

  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int                CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The limit is reached on the stall cycle in which the count would step
  // from TIMEOUT_CYCLES-1 to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;

  logic can_accept;
  logic accept;
  logic resp_err;
  logic timeout_hit;

  // Bursts are always split into singles, and SEQ is treated like NONSEQ.
  // These input bits therefore carry no information for the bridge.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST_MASTER, HTRANS_MASTER[0]};

  // A new transfer may only be taken while the upstream data phase is
  // completing, that is whenever HREADYOUT_MASTER is high.
  assign can_accept  = (state_reg == ST_IDLE) || (state_reg == ST_RESP) ||
                       (state_reg == ST_ERR2);
  assign accept      = can_accept && HSEL && HREADY && HTRANS_MASTER[1];
  // Any non-OKAY downstream response is folded into ERROR.
  assign resp_err    = (HRESP_SLAVE != HRESP_OKAY);
  // A completing downstream beat wins over a timeout in the same cycle.
  assign timeout_hit = TIMEOUT_EN && (state_reg == ST_DATA) && !HREADY_SLAVE &&
                       (count_reg == CNT_LAST);

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_RESP, ST_ERR2: state_next = accept ? ST_ADDR : ST_IDLE;
      ST_ADDR:                   if (HREADY_SLAVE) state_next = ST_DATA;
      ST_DATA: begin
        if (HREADY_SLAVE) begin
          state_next = resp_err ? ST_ERR1 : ST_RESP;
        end else if (timeout_hit) begin
          state_next = ST_ERR1;
        end
      end
      ST_ERR1:                   state_next = ST_ERR2;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Upstream response and timeout strobe, decoded from the current state
  always_comb begin
    HREADYOUT_MASTER = 1'b1;
    HRESP_MASTER     = HRESP_OKAY;
    TIMEOUT_PULSE    = timeout_hit;
    case (state_reg)
      ST_ADDR, ST_DATA: HREADYOUT_MASTER = 1'b0;
      ST_ERR1: begin
        HREADYOUT_MASTER = 1'b0;
        HRESP_MASTER     = HRESP_ERROR;
      end
      ST_ERR2:          HRESP_MASTER     = HRESP_ERROR;
      default: begin
        HREADYOUT_MASTER = 1'b1;
        HRESP_MASTER     = HRESP_OKAY;
      end
    endcase
  end

  // Downstream address/control and write data registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HADDR_SLAVE     <= '0;
      HTRANS_SLAVE    <= HTRANS_IDLE;
      HSIZE_SLAVE     <= '0;
      HBURST_SLAVE    <= '0;
      HPROT_SLAVE     <= '0;
      HWRITE_SLAVE    <= 1'b0;
      HMASTLOCK_SLAVE <= 1'b0;
      HWDATA_SLAVE    <= '0;
    end else begin
      if (accept) begin
        HADDR_SLAVE     <= HADDR_MASTER;
        HTRANS_SLAVE    <= HTRANS_NONSEQ;
        HSIZE_SLAVE     <= HSIZE_MASTER;
        HBURST_SLAVE    <= HBURST_SINGLE;
        HPROT_SLAVE     <= HPROT_MASTER;
        HWRITE_SLAVE    <= HWRITE_MASTER;
        HMASTLOCK_SLAVE <= HMASTLOCK_MASTER;
      end else if ((state_reg == ST_ADDR) && HREADY_SLAVE) begin
        // The address phase has been taken downstream, so a single NONSEQ
        // is issued per transfer.
        HTRANS_SLAVE <= HTRANS_IDLE;
      end
      // Upstream write data is valid throughout the ADDR cycles. It is held
      // for the downstream data phase.
      if (state_reg == ST_ADDR) begin
        HWDATA_SLAVE <= HWDATA_MASTER;
      end
    end
  end

  // Read data returned upstream: valid in the RESP cycle only, zero otherwise
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HRDATA_MASTER <= '0;
    end else if ((state_reg == ST_DATA) && HREADY_SLAVE && !resp_err) begin
      HRDATA_MASTER <= HRDATA_SLAVE;
    end else begin
      HRDATA_MASTER <= '0;
    end
  end

  // Downstream stall counter: cleared when a transfer is accepted, and
  // counting (saturating) in DATA while the downstream slave waits
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= '0;
    end else if ((state_reg == ST_DATA) && !HREADY_SLAVE && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule
